conv_kxk_stream: RTL and testbench

CONV_KXK_STREAM -- requirements
Module: conv_kxk_stream

---
 rtl/conv_kxk_stream_pkg.sv | 37 +++
 rtl/conv_kxk_stream_round_sat.sv | 37 +++
 rtl/conv_kxk_stream.sv | 134 +++++++++++++
 tb/tb_conv_kxk_stream.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_kxk_stream_pkg.sv
// Shared constants and elaboration-time helpers for the KxK streaming convolver.
package conv_kxk_stream_pkg;

    localparam int DEF_K     = 3;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_COE_W = 8;
    localparam int DEF_FRAC  = 7;
    localparam int DEF_OUT_W = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Number of live terms left after lvl pairwise reduction levels of n terms.
    function automatic int tree_cnt(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

    // Half-up rounding offset added before the arithmetic right shift.
    function automatic int rnd_bias(input int frac);
        return (frac > 0) ? (1 << (frac - 1)) : 0;
    endfunction

    // Two's-complement limits of a w-bit signed result.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/conv_kxk_stream_round_sat.sv
// Combinational round / saturate / ReLU core; the parent registers its output.
module conv_round_sat
    import conv_kxk_stream_pkg::*;
#(
    parameter int ACC_W = 21,
    parameter int FRAC  = DEF_FRAC,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic                    relu_i,
    output logic signed [OUT_W-1:0] res_o
);

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    localparam logic signed [ACC_W:0] BIAS = (ACC_W + 1)'(rnd_bias(FRAC));
    localparam logic signed [ACC_W:0] SMAX = (ACC_W + 1)'(sat_max(OUT_W));
    localparam logic signed [ACC_W:0] SMIN = (ACC_W + 1)'(sat_min(OUT_W));

    logic signed [ACC_W:0]   sum_w;
    logic signed [ACC_W:0]   shr_w;
    logic signed [OUT_W-1:0] sat_w;

    // Half-up round, clamp to the output range, then zero negatives when ReLU is on.
    always_comb begin
        sum_w = {acc_i[ACC_W-1], acc_i} + BIAS;
        shr_w = sum_w >>> FRAC;
        if (shr_w > SMAX) begin
            sat_w = SMAX[OUT_W-1:0];
        end else if (shr_w < SMIN) begin
            sat_w = SMIN[OUT_W-1:0];
        end else begin
            sat_w = shr_w[OUT_W-1:0];
        end
        res_o = (relu_i && sat_w[OUT_W-1]) ? '0 : sat_w;
    end

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming KxK convolution: one window per accepted transfer, T+2 stage
// pipeline (products, pairwise adder tree, round/saturate) that stalls as a
// whole on output backpressure. Coefficients are double-buffered.
module conv_kxk_stream
    import conv_kxk_stream_pkg::*;
#(
    parameter int K     = DEF_K,
    parameter int PIX_W = DEF_PIX_W,
    parameter int COE_W = DEF_COE_W,
    parameter int FRAC  = DEF_FRAC,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [K*K*PIX_W-1:0]        win,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    input  logic                        coe_wr_en,
    input  logic [clog2(K*K)-1:0]       coe_wr_addr,
    input  logic [COE_W-1:0]            coe_wr_data,
    input  logic                        coe_swap,
    input  logic                        relu_en
);

    localparam int NT    = K * K;
    localparam int T     = clog2(NT);
    localparam int AW    = clog2(NT);
    localparam int PW    = PIX_W + 1 + COE_W;
    localparam int ACC_W = PW + T;
    localparam int NS    = T + 2;
    localparam int NL    = (NT + 1) / 2;

    logic signed [COE_W-1:0] shd_q [NT];
    logic signed [COE_W-1:0] act_q [NT];
    logic signed [PW-1:0]    prod_w [NT];

    // Level 0 holds the products, level T holds the full sum in entry 0.
    logic signed [ACC_W-1:0] tree_d [T+1][NT+1];
    logic signed [ACC_W-1:0] tree_q [T+1][NT+1];

    logic [NS-1:0]           vld_q;
    logic [T:0]              relu_q;
    logic signed [OUT_W-1:0] res_w;
    logic signed [OUT_W-1:0] out_q;
    logic                    adv;

    assign adv       = !vld_q[NS-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[NS-1];
    assign out_data  = out_q;

    // Pixels are unsigned, so a zero MSB is prepended before the signed multiply.
    always_comb begin
        for (int i = 0; i < NT; i++) begin
            prod_w[i] = PW'($signed({1'b0, win[i*PIX_W +: PIX_W]})) * PW'(act_q[i]);
        end
    end

    // Next-state of the product stage and the pairwise adder tree; an odd
    // leftover term at any level is forwarded unchanged to the next level.
    always_comb begin
        for (int lv = 0; lv <= T; lv++) begin
            for (int i = 0; i <= NT; i++) begin
                tree_d[lv][i] = '0;
            end
        end
        for (int i = 0; i < NT; i++) begin
            tree_d[0][i] = ACC_W'(prod_w[i]);
        end
        for (int lv = 1; lv <= T; lv++) begin
            for (int i = 0; i < NL; i++) begin
                if (i < tree_cnt(NT, lv)) begin
                    if (2 * i + 1 < tree_cnt(NT, lv - 1)) begin
                        tree_d[lv][i] = tree_q[lv-1][2*i] + tree_q[lv-1][2*i+1];
                    end else begin
                        tree_d[lv][i] = tree_q[lv-1][2*i];
                    end
                end
            end
        end
    end

    conv_round_sat #(
        .ACC_W (ACC_W),
        .FRAC  (FRAC),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc_i  (tree_q[T][0]),
        .relu_i (relu_q[T]),
        .res_o  (res_w)
    );

    // Shadow takes writes; a swap copies the pre-write shadow into the active bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                shd_q[i] <= '0;
                act_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NT; i++) begin
                if (coe_wr_en && (coe_wr_addr == AW'(i))) begin
                    shd_q[i] <= coe_wr_data;
                end
                if (coe_swap) begin
                    act_q[i] <= shd_q[i];
                end
            end
        end
    end

    // All stages move together on adv; bubbles travel as cleared valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            relu_q <= '0;
            out_q  <= '0;
            for (int lv = 0; lv <= T; lv++) begin
                for (int i = 0; i <= NT; i++) begin
                    tree_q[lv][i] <= '0;
                end
            end
        end else if (adv) begin
            vld_q  <= {vld_q[NS-2:0], in_valid};
            relu_q <= {relu_q[T-1:0], relu_en};
            tree_q <= tree_d;
            out_q  <= res_w;
        end
    end

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Directed bench for conv_kxk_stream at K=3 with default widths.
module tb_conv_kxk_stream;

    localparam int K  = 3;
    localparam int NT = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] win;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        coe_wr_en;
    logic [3:0]  coe_wr_addr;
    logic [7:0]  coe_wr_data;
    logic        coe_swap;
    logic        relu_en;

    always #5 clk = ~clk;

    conv_kxk_stream #(
        .K(K), .PIX_W(8), .COE_W(8), .FRAC(7), .OUT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .win(win),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coe_wr_en(coe_wr_en), .coe_wr_addr(coe_wr_addr), .coe_wr_data(coe_wr_data),
        .coe_swap(coe_swap), .relu_en(relu_en)
    );

    typedef struct {
        logic [71:0] coe;
        logic [71:0] pix;
        logic        relu;
        int          exp;
        string       name;
    } vec_t;

    vec_t tbl [12];
    int   n_vec = 0;
    int   n_bad = 0;

    int   s_got [$];
    int   sw_got [$];
    int   drv_g;
    logic drv_acc;
    logic snk_pv, snk_pr;
    int   snk_pd;
    logic ghost;

    function automatic logic [71:0] one(input int idx, input int val);
        logic [71:0] f;
        f = '0;
        f[idx*8 +: 8] = 8'(val);
        return f;
    endfunction

    function automatic logic [71:0] all_of(input int val);
        logic [71:0] f;
        for (int i = 0; i < NT; i++) f[i*8 +: 8] = 8'(val);
        return f;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coe(input int addr, input int data);
        coe_wr_en   = 1'b1;
        coe_wr_addr = 4'(addr);
        coe_wr_data = 8'(data);
        tick();
        coe_wr_en   = 1'b0;
    endtask

    // Fill the shadow, poke the unmapped addresses, then swap into active.
    task automatic load_bank(input logic [71:0] c);
        for (int i = 0; i < NT; i++) wr_coe(i, int'($signed(c[i*8 +: 8])));
        for (int a = 9; a < 16; a++) wr_coe(a, 127);
        coe_swap = 1'b1;
        tick();
        coe_swap = 1'b0;
    endtask

    task automatic send_one(input logic [71:0] w, input logic r, input int exp, input string nm);
        int lat;
        win      = w;
        relu_en  = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        relu_en  = 1'b0;
        win      = '0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({nm, "_data"}, int'($signed(out_data)), exp);
        check({nm, "_lat"}, lat, 6);
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; win = '0; out_ready = 1'b1;
        coe_wr_en = 1'b0; coe_wr_addr = '0; coe_wr_data = '0;
        coe_swap = 1'b0; relu_en = 1'b0;

        tbl[0]  = '{one(4, 64),  one(4, 200), 1'b0, 100,  "centre200"};
        tbl[1]  = '{one(4, 1),   one(4, 64),  1'b0, 1,    "round64"};
        tbl[2]  = '{one(4, 1),   one(4, 63),  1'b0, 0,    "round63"};
        tbl[3]  = '{all_of(127), all_of(255), 1'b0, 127,  "sat_pos"};
        tbl[4]  = '{one(4, -128), one(4, 255), 1'b0, -128, "sat_neg"};
        tbl[5]  = '{one(4, -128), one(4, 255), 1'b1, 0,    "relu_sat_neg"};
        tbl[6]  = '{one(4, -1),  one(4, 65),  1'b0, -1,   "neg_round65"};
        tbl[7]  = '{one(4, -1),  one(4, 64),  1'b0, 0,    "neg_round64"};
        tbl[8]  = '{one(4, -1),  one(4, 65),  1'b1, 0,    "relu_small"};
        tbl[9]  = '{one(8, 127) | one(1, -128), one(8, 100) | one(1, 50), 1'b0, 49, "mixed"};
        tbl[10] = '{one(4, 64),  one(4, 200), 1'b1, 100,  "relu_pos"};
        tbl[11] = '{one(0, -64) | one(4, 64), one(0, 10) | one(4, 100), 1'b0, 45, "two_taps"};

        // Reset state
        tick();
        tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_data", int'($signed(out_data)), 0);
        rst = 1'b0;
        tick();

        // Table-driven single windows
        for (int v = 0; v < 12; v++) begin
            load_bank(tbl[v].coe);
            send_one(tbl[v].pix, tbl[v].relu, tbl[v].exp, tbl[v].name);
        end

        // Streaming with a 3-cycle downstream stall
        load_bank(one(4, 64));
        s_got.delete();
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    in_valid = 1'b1;
                    win      = one(4, 20 * (k + 1));
                    drv_g    = 0;
                    do begin
                        @(negedge clk);
                        drv_acc = in_ready;
                        @(posedge clk);
                        #1;
                        drv_g++;
                    end while (!drv_acc && drv_g < 60);
                    check("stream_accept", int'(drv_acc), 1);
                end
                in_valid = 1'b0;
                win      = '0;
            end
            begin
                snk_pv = 1'b0;
                snk_pr = 1'b1;
                snk_pd = 0;
                for (int c = 0; c < 40; c++) begin
                    out_ready = !(c >= 6 && c < 9);
                    @(negedge clk);
                    check("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
                    if (snk_pv && !snk_pr) check("stall_hold", int'($signed(out_data)), snk_pd);
                    if (out_valid && out_ready) s_got.push_back(int'($signed(out_data)));
                    snk_pv = out_valid;
                    snk_pr = out_ready;
                    snk_pd = int'($signed(out_data));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        check("stream_count", s_got.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check("stream_order", (k < s_got.size()) ? s_got[k] : -999, 10 * (k + 1));
        end

        // Swap with transfers in flight: old bank centre 32, new bank centre 64
        load_bank(one(4, 32));
        wr_coe(4, 64);
        win = one(4, 100);
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        coe_swap = 1'b1;
        tick();
        coe_swap = 1'b0;
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        sw_got.delete();
        for (int c = 0; c < 20; c++) begin
            if (out_valid) sw_got.push_back(int'($signed(out_data)));
            tick();
        end
        check("swap_count", sw_got.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check("swap_result", (k < sw_got.size()) ? sw_got[k] : -999, (k < 3) ? 25 : 50);
        end

        // Write and swap on the same edge: active gets the pre-write value
        coe_wr_en = 1'b1; coe_wr_addr = 4'd4; coe_wr_data = 8'(-64); coe_swap = 1'b1;
        tick();
        coe_wr_en = 1'b0; coe_swap = 1'b0;
        send_one(one(4, 100), 1'b0, 50, "sameedge_old");
        coe_swap = 1'b1;
        tick();
        coe_swap = 1'b0;
        send_one(one(4, 100), 1'b0, -50, "sameedge_new");

        // Asynchronous reset with transfers in flight
        win = one(4, 100);
        in_valid = 1'b1;
        repeat (8) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'($signed(out_data)), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        win = '0;
        tick();
        rst = 1'b0;
        ghost = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) ghost = 1'b1;
        end
        check("no_ghost", int'(ghost), 0);
        send_one(one(4, 100), 1'b0, 0, "banks_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
